// File: rtl/invader_pkg.sv
// Shared definitions for the invader tracker: coordinate type, FSM states,
// screen geometry, score cap and small coordinate helpers.
package invader_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SCORE_W  = 14;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SCORE_W-1:0] score_t;

  localparam score_t SCORE_CAP   = score_t'(9999);
  // A shot sitting on the bottom row is retired instead of advanced.
  localparam coord_t SHOT_LAST_Y = coord_t'(SCREEN_H - 1);
  // Player-vs-shot proximity window (strictly less than).
  localparam coord_t HIT_RADIUS  = coord_t'(10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DYING = 2'd2
  } state_t;

  // Unsigned distance; ordering the operands avoids wrap-around.
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // One unit step of cur toward target, holding when already there.
  function automatic coord_t step_toward(input coord_t cur, input coord_t target);
    if (cur < target)
      return cur + coord_t'(1);
    else if (cur > target)
      return cur - coord_t'(1);
    else
      return cur;
  endfunction

endpackage

// File: rtl/invader_shot_slot.sv
// One enemy-shot slot: load at the enemy, fall one row per cycle, retire at
// the bottom or on a player hit. A free slot parks at (0,0).
// Optional build macro INVADER_HOMING_EN: on each move tick a live shot also
// steps its x one unit toward the player.
module invader_shot_slot
  import invader_pkg::*;
(
  input  logic   clk_4,
  input  logic   clr,
  input  logic   flush,
  input  logic   load,
  input  coord_t load_x,
  input  coord_t load_y,
  input  logic   tick,
  input  coord_t player_x,
  input  coord_t player_y,
  output coord_t x,
  output coord_t y,
  output logic   valid,
  output logic   hit
);

`ifdef INVADER_HOMING_EN
  localparam bit HOMING = 1'b1;
`else
  localparam bit HOMING = 1'b0;
`endif

  // Live shot overlapping the player this cycle.
  assign hit = valid
            && (abs_diff(x, player_x) < HIT_RADIUS)
            && (abs_diff(y, player_y) < HIT_RADIUS);

  // Slot state: flush beats load, load only lands in a free slot.
  always_ff @(posedge clk_4 or posedge clr) begin
    if (clr) begin
      x     <= '0;
      y     <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      x     <= '0;
      y     <= '0;
      valid <= 1'b0;
    end else if (load && !valid) begin
      x     <= load_x;
      y     <= load_y;
      valid <= 1'b1;
    end else if (valid) begin
      if (hit || (y >= SHOT_LAST_Y)) begin
        x     <= '0;
        y     <= '0;
        valid <= 1'b0;
      end else begin
        y <= y + coord_t'(1);
        if (HOMING && tick)
          x <= step_toward(x, player_x);
      end
    end
  end

endmodule

// File: rtl/invader_tracker.sv
// Single enemy that tracks the player horizontally, fires falling shots from
// a small pool of slots, dies when hit by a player bullet and respawns.
// Optional build macro INVADER_HOMING_EN (handled in invader_shot_slot).
// Handshake note: there is no valid/ready traffic here; every input is
// sampled each clock and collision/player_hit are single-cycle pulses.
module invader_tracker
  import invader_pkg::*;
#(
  parameter int NUM_SHOTS   = 4,
  parameter int MOVE_DIV    = 3,
  parameter int SPAWN_X     = 220,
  parameter int SPAWN_Y     = 30,
  parameter int FIRE_LO     = 30,
  parameter int FIRE_HI     = 40,
  parameter int RESPAWN_CYC = 64
) (
  input  logic                     clk_4,
  input  logic                     clr,
  input  logic                     play,
  input  logic [7:0]               rand_byte,
  input  logic                     destroy,
  input  logic [COORD_W-1:0]       projectiles_x,
  input  logic [COORD_W-1:0]       projectiles_y,
  input  logic [COORD_W-1:0]       player_x,
  input  logic [COORD_W-1:0]       player_y,
  output logic [COORD_W-1:0]       enemy_x,
  output logic [COORD_W-1:0]       enemy_y,
  output logic [NUM_SHOTS*10-1:0]  shot_x,
  output logic [NUM_SHOTS*10-1:0]  shot_y,
  output logic [NUM_SHOTS-1:0]     shot_valid,
  output logic                     collision,
  output logic                     player_hit,
  output logic [SCORE_W-1:0]       score,
  output state_t                   fsm_state
);

  localparam int DIV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int RESP_W = $clog2(RESPAWN_CYC + 1);
  localparam logic [7:0] FIRE_LO_B = 8'(FIRE_LO);
  localparam logic [7:0] FIRE_HI_B = 8'(FIRE_HI);

  logic [DIV_W-1:0]     div_cnt;
  logic [RESP_W-1:0]    resp_cnt;
  logic                 tick;
  logic                 enemy_hit;
  logic                 fire_req;
  logic                 flush;
  logic [NUM_SHOTS-1:0] load_sel;
  logic [NUM_SHOTS-1:0] slot_hit;

  assign tick = (div_cnt == DIV_W'(MOVE_DIV - 1));

  // Player bullet inside the enemy box: strictly below, under 20 rows, under 15 columns.
  assign enemy_hit = (fsm_state == ST_TRACK)
                  && (projectiles_y != '0)
                  && (projectiles_y > enemy_y)
                  && ((projectiles_y - enemy_y) < coord_t'(20))
                  && (abs_diff(projectiles_x, enemy_x) < coord_t'(15));

  // Launch request; destroy cancels it for the cycle.
  assign fire_req = play && (fsm_state == ST_TRACK) && !destroy
                 && (rand_byte > FIRE_LO_B) && (rand_byte < FIRE_HI_B);

  // Shots are wiped on destroy and whenever the game is not running.
  assign flush = destroy || !play || (fsm_state == ST_IDLE);

  // Pick the lowest free slot (one-hot, all zero when the pool is full).
  always_comb begin
    load_sel = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!shot_valid[i] && (load_sel == '0))
        load_sel[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    invader_shot_slot u_slot (
      .clk_4    (clk_4),
      .clr      (clr),
      .flush    (flush),
      .load     (fire_req && load_sel[g]),
      .load_x   (enemy_x),
      .load_y   (enemy_y + coord_t'(1)),
      .tick     (tick),
      .player_x (player_x),
      .player_y (player_y),
      .x        (shot_x[g*10 +: 10]),
      .y        (shot_y[g*10 +: 10]),
      .valid    (shot_valid[g]),
      .hit      (slot_hit[g])
    );
  end

  // Game FSM with registered enemy position, score and event pulses.
  always_ff @(posedge clk_4 or posedge clr) begin
    if (clr) begin
      fsm_state  <= ST_IDLE;
      enemy_x    <= coord_t'(SPAWN_X);
      enemy_y    <= coord_t'(SPAWN_Y);
      score      <= '0;
      collision  <= 1'b0;
      player_hit <= 1'b0;
      div_cnt    <= '0;
      resp_cnt   <= '0;
    end else begin
      collision  <= 1'b0;
      player_hit <= play && (fsm_state != ST_IDLE) && !destroy && (|slot_hit);
      if (!play) begin
        fsm_state <= ST_IDLE;
        div_cnt   <= '0;
        resp_cnt  <= '0;
      end else begin
        case (fsm_state)
          ST_IDLE: begin
            fsm_state <= ST_TRACK;
            enemy_x   <= coord_t'(SPAWN_X);
            enemy_y   <= coord_t'(SPAWN_Y);
            score     <= '0;
            div_cnt   <= '0;
            resp_cnt  <= '0;
          end
          ST_TRACK: begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (enemy_hit) begin
              collision <= 1'b1;
              score     <= (score < SCORE_CAP) ? score + score_t'(1) : score;
              fsm_state <= ST_DYING;
              resp_cnt  <= '0;
            end else if (tick) begin
              enemy_x <= step_toward(enemy_x, player_x);
            end
          end
          ST_DYING: begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (resp_cnt == RESP_W'(RESPAWN_CYC - 1)) begin
              fsm_state <= ST_TRACK;
              enemy_x   <= coord_t'(20) + coord_t'({rand_byte, 1'b0});
              enemy_y   <= coord_t'(SPAWN_Y);
              resp_cnt  <= '0;
            end else begin
              resp_cnt <= resp_cnt + RESP_W'(1);
            end
          end
          default: fsm_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_invader_tracker.sv
// Directed bench for invader_tracker: reset, tracking, shot pool, retirement,
// destroy, collision/respawn, player hit, optional homing and async clear.
module tb_invader_tracker;
  import invader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_4 = 1'b0;
  always #5 clk_4 = ~clk_4;

  logic        clr, play, destroy;
  logic [7:0]  rand_byte;
  logic [9:0]  projectiles_x, projectiles_y, player_x, player_y;
  logic [9:0]  enemy_x, enemy_y;
  logic [39:0] shot_x, shot_y;
  logic [3:0]  shot_valid;
  logic        collision, player_hit;
  logic [13:0] score;
  state_t      fsm_state;

  invader_tracker dut (
    .clk_4         (clk_4),
    .clr           (clr),
    .play          (play),
    .rand_byte     (rand_byte),
    .destroy       (destroy),
    .projectiles_x (projectiles_x),
    .projectiles_y (projectiles_y),
    .player_x      (player_x),
    .player_y      (player_y),
    .enemy_x       (enemy_x),
    .enemy_y       (enemy_y),
    .shot_x        (shot_x),
    .shot_y        (shot_y),
    .shot_valid    (shot_valid),
    .collision     (collision),
    .player_hit    (player_hit),
    .score         (score),
    .fsm_state     (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] sx(input int i);
    return shot_x[i*10 +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return shot_y[i*10 +: 10];
  endfunction

  // ---------------- driver helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1; play = 1'b0; destroy = 1'b0; rand_byte = 8'd0;
    projectiles_x = '0; projectiles_y = '0;
    player_x = 10'd230; player_y = 10'd0;
    step(2);

    // reset state
    check_val("rst_state",  32'(fsm_state), 32'(ST_IDLE));
    check_val("rst_ex",     32'(enemy_x), 32'd220);
    check_val("rst_ey",     32'(enemy_y), 32'd30);
    check_val("rst_valid",  32'(shot_valid), 32'd0);
    check_val("rst_sx",     32'(shot_x), 32'd0);
    check_val("rst_sy",     32'(shot_y), 32'd0);
    check_val("rst_coll",   32'(collision), 32'd0);
    check_val("rst_phit",   32'(player_hit), 32'd0);
    check_val("rst_score",  32'(score), 32'd0);

    // tracking: 220 -> 230 over 10 ticks of 3 cycles
    clr = 1'b0; play = 1'b1;
    step(1);
    check_val("trk_state",  32'(fsm_state), 32'(ST_TRACK));
    check_val("trk_ex0",    32'(enemy_x), 32'd220);
    step(29);
    check_val("trk_ex29",   32'(enemy_x), 32'd229);
    step(1);
    check_val("trk_ex30",   32'(enemy_x), 32'd230);
    check_val("trk_ey",     32'(enemy_y), 32'd30);
    step(6);
    check_val("trk_hold",   32'(enemy_x), 32'd230);

    // fire window held for 5 cycles: four launches, fifth ignored
    rand_byte = 8'd35;
    step(1); check_val("fire_v1", 32'(shot_valid), 32'b0001);
    check_val("fire_y1", 32'(sy(0)), 32'd31);
    step(1); check_val("fire_v2", 32'(shot_valid), 32'b0011);
    step(1); check_val("fire_v3", 32'(shot_valid), 32'b0111);
    step(1); check_val("fire_v4", 32'(shot_valid), 32'b1111);
    step(1); check_val("fire_v5", 32'(shot_valid), 32'b1111);
    rand_byte = 8'd0;
    exp_q.push_back(32'd35); exp_q.push_back(32'd34);
    exp_q.push_back(32'd33); exp_q.push_back(32'd32);
    for (int i = 0; i < 4; i++) begin
      check_val("fire_sy", 32'(sy(i)), exp_q.pop_front());
      check_val("fire_sx", 32'(sx(i)), 32'd230);
    end

    // retirement at the bottom row
    step(444);
    check_val("ret_y479",  32'(sy(0)), 32'd479);
    check_val("ret_v_pre", 32'(shot_valid), 32'b1111);
    step(1);
    check_val("ret_v1",    32'(shot_valid), 32'b1110);
    check_val("ret_y0",    32'(sy(0)), 32'd0);
    check_val("ret_x0",    32'(sx(0)), 32'd0);
    step(1);
    check_val("ret_v2",    32'(shot_valid), 32'b1100);
    step(2);
    check_val("ret_v4",    32'(shot_valid), 32'b0000);

    // destroy clears all and blocks the same-cycle launch
    rand_byte = 8'd35;
    step(3);
    check_val("dst_pre",   32'(shot_valid), 32'b0111);
    destroy = 1'b1;
    step(1);
    check_val("dst_v",     32'(shot_valid), 32'b0000);
    check_val("dst_sy",    32'(shot_y), 32'd0);
    destroy = 1'b0; rand_byte = 8'd0;
    step(1);
    check_val("dst_after", 32'(shot_valid), 32'b0000);

    // collision boundaries, then a hit
    projectiles_x = 10'd230; projectiles_y = 10'd50;
    step(1); check_val("col_dy20", 32'(collision), 32'd0);
    projectiles_x = 10'd245; projectiles_y = 10'd40;
    step(1); check_val("col_dx15", 32'(collision), 32'd0);
    check_val("col_st0",  32'(fsm_state), 32'(ST_TRACK));
    projectiles_x = 10'd235; projectiles_y = 10'd40;
    step(1);
    check_val("col_hit",   32'(collision), 32'd1);
    check_val("col_score", 32'(score), 32'd1);
    check_val("col_state", 32'(fsm_state), 32'(ST_DYING));
    projectiles_y = 10'd0; rand_byte = 8'd35;
    step(1);
    check_val("col_pulse", 32'(collision), 32'd0);
    step(61);
    check_val("dy_state62", 32'(fsm_state), 32'(ST_DYING));
    check_val("dy_nofire",  32'(shot_valid), 32'd0);
    rand_byte = 8'd50; player_x = 10'd120;
    step(1);
    check_val("dy_state63", 32'(fsm_state), 32'(ST_DYING));
    step(1);
    check_val("rsp_state", 32'(fsm_state), 32'(ST_TRACK));
    check_val("rsp_ex",    32'(enemy_x), 32'd120);
    check_val("rsp_ey",    32'(enemy_y), 32'd30);

    // player hit at the vertical edge of the window
    rand_byte = 8'd35;
    step(1);
    check_val("ph_launch", 32'(shot_valid), 32'b0001);
    check_val("ph_sx",     32'(sx(0)), 32'd120);
    rand_byte = 8'd0; player_y = 10'd45;
    step(5);
    check_val("ph_none",   32'(player_hit), 32'd0);
    check_val("ph_y36",    32'(sy(0)), 32'd36);
    step(1);
    check_val("ph_hit",    32'(player_hit), 32'd1);
    check_val("ph_freed",  32'(shot_valid), 32'd0);
    step(1);
    check_val("ph_pulse",  32'(player_hit), 32'd0);

`ifdef INVADER_HOMING_EN
    // homing steers toward the player one step per tick
    player_y = 10'd0; rand_byte = 8'd35;
    step(1);
    rand_byte = 8'd0; player_x = 10'd126;
    step(3);
    check_val("hom_x1", 32'(sx(0)), 32'd121);
    step(3);
    check_val("hom_x2", 32'(sx(0)), 32'd122);
    check_val("hom_y",  32'(sy(0)), 32'd37);
    player_y = 10'd40;
    step(1);
    check_val("hom_hit",  32'(player_hit), 32'd1);
    check_val("hom_free", 32'(shot_valid), 32'd0);
    step(1);
    check_val("hom_pulse", 32'(player_hit), 32'd0);
`endif

    // asynchronous clear mid-flight
    player_y = 10'd0; rand_byte = 8'd35;
    step(1);
    check_val("clr_pre", 32'(shot_valid[0]), 32'd1);
    rand_byte = 8'd0;
    #2 clr = 1'b1;
    #1;
    check_val("clr_state", 32'(fsm_state), 32'(ST_IDLE));
    check_val("clr_valid", 32'(shot_valid), 32'd0);
    check_val("clr_ex",    32'(enemy_x), 32'd220);
    check_val("clr_score", 32'(score), 32'd0);
    check_val("clr_phit",  32'(player_hit), 32'd0);
    @(negedge clk_4);
    clr = 1'b0;
    step(1);
    check_val("clr_track", 32'(fsm_state), 32'(ST_TRACK));
    play = 1'b0;
    step(1);
    check_val("play_idle", 32'(fsm_state), 32'(ST_IDLE));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/invader_tracker.md
INVADER_TRACKER -- requirements
Module: invader_tracker

Interface
REQ-001 Parameter NUM_SHOTS, default 4, meaning number of independent enemy-shot slots (1..8).
REQ-002 Parameter MOVE_DIV, default 3, meaning clk_4 cycles per enemy/steer move tick (>=1).
REQ-003 Parameter SPAWN_X / SPAWN_Y, default 220 / 30, meaning enemy position after a play start.
REQ-004 Parameter FIRE_LO / FIRE_HI, default 30 / 40, meaning exclusive rand window that requests a shot.
REQ-005 Parameter RESPAWN_CYC, default 64, meaning cycles spent in DYING before respawn.
REQ-006 clk_4  in  1  sole clock, all state on rising edge.
REQ-007 clr  in  1  asynchronous, active-high reset.
REQ-008 play  in  1  game running; 0 forces IDLE.
REQ-009 rand  in  8  pseudo-random byte, sampled every cycle.
REQ-010 destroy  in  1  clears all enemy shots this cycle.
REQ-011 projectiles_x / projectiles_y  in  10 each  player bullet position (y=0 means none).
REQ-012 player_x / player_y  in  10 each  player ship position.
REQ-013 enemy_x / enemy_y  out  10 each  enemy position.
REQ-014 shot_x / shot_y  out  NUM_SHOTS*10 each  packed shot positions, slot i at bits [10i+9:10i].
REQ-015 shot_valid  out  NUM_SHOTS  slot occupied.
REQ-016 collision  out  1  one-cycle pulse, enemy hit by player bullet.
REQ-017 player_hit  out  1  one-cycle pulse, player hit by an enemy shot.
REQ-018 score  out  14  enemy kills, saturating at 9999.

Function
REQ-019 FSM states IDLE, TRACK, DYING; IDLE->TRACK when play=1, any state->IDLE when play=0, TRACK->DYING on hit, DYING->TRACK after RESPAWN_CYC cycles.
REQ-020 Entering TRACK from IDLE loads enemy (SPAWN_X,SPAWN_Y), clears score and all shots.
REQ-021 Move tick: divider counts 0..MOVE_DIV-1, ticks at MOVE_DIV-1, runs in all states, cleared in IDLE.
REQ-022 In TRACK on tick, enemy_x moves 1 toward player_x; unchanged when equal; enemy_y constant.
REQ-023 Hit: TRACK, projectiles_y!=0, 0<projectiles_y-enemy_y<20, |projectiles_x-enemy_x|<15 -> collision=1 for one cycle, score+1 (saturating), enter DYING.
REQ-024 DYING exit sets enemy_x = 20 + {rand,1'b0} (range 20..530), enemy_y = SPAWN_Y.
REQ-025 Fire: TRACK only; FIRE_LO<rand<FIRE_HI and any slot free -> lowest free slot loads (enemy_x, enemy_y+1), valid=1, next cycle; max one launch per cycle.
REQ-026 Each valid shot: y increments 1 per cycle; y>=479 before increment -> slot freed.
REQ-027 Valid shot with |shot_x-player_x|<10 and |shot_y-player_y|<10 -> player_hit=1 one cycle, slot freed; multiple simultaneous hits give one pulse, all freed.
REQ-028 destroy=1 frees all slots and suppresses that cycle's launch; freed slot outputs x=y=0.
REQ-029 Shots keep moving in DYING; no launch in DYING.
REQ-030 All coordinate arithmetic unsigned 10-bit; differences computed with explicit compare ordering, no wrap.

Reset
REQ-031 clr=1 asynchronously forces IDLE, enemy (SPAWN_X,SPAWN_Y), all shots invalid at (0,0), collision=0, player_hit=0, score=0, counters 0.
REQ-032 clr mid-DYING or mid-flight discards the respawn counter and shots; no pulse emitted.

Configuration
REQ-033 With INVADER_HOMING_EN defined, on each move tick every valid shot steps shot_x 1 toward player_x; without it, shot_x is fixed at launch.

Structure
REQ-034 Shared package invader_pkg holds FSM state typedef, SCREEN_H=480, SCREEN_W=640, coordinate width 10, score cap 9999.
REQ-035 Sub-module invader_shot_slot (one per slot via generate): load, advance, homing, retire, player-hit compare.

Verification
REQ-036 clr, play=1, player_x=230 -> enemy_x 220->230 in 10 ticks (30 cycles, MOVE_DIV=3), then holds.
REQ-037 rand=35 for 5 cycles, NUM_SHOTS=4 -> slots 0..3 launched one per cycle, 5th request ignored, all at enemy_y+1.
REQ-038 Bullet (enemy_x+5, enemy_y+10) -> collision pulse 1 cycle, score 0->1, enemy respawns after 64 cycles at 20+2*rand.
REQ-039 Shot reaches y=479 -> valid drops next cycle; destroy=1 with 3 valid shots -> all invalid, rand=35 same cycle launches nothing.
REQ-040 INVADER_HOMING_EN defined, player_x=shot_x+6, player_y aligned -> shot steers 1 per tick, player_hit pulse once, slot freed.
